// File: rtl/led_tatdan_pkg.sv
// Shared phase codes and sizing helper for the led_tatdan LED bar sequencer.
package led_tatdan_pkg;

   localparam int PHASE_W = 3;

   // Codes 5..7 are unused and fall back to IDLE.
   typedef enum logic [PHASE_W-1:0] {
      PH_IDLE       = 3'd0,
      PH_FILL       = 3'd1,
      PH_FULL_HOLD  = 3'd2,
      PH_DRAIN      = 3'd3,
      PH_EMPTY_HOLD = 3'd4
   } phase_e;

   // Hold counter width: max(1, clog2(hold+1)).
   function automatic int cnt_w(input int hold);
      int w;
      w = $clog2(hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/led_tatdan_xung.sv
// xung_edge: synchronizes the slow clk_hz square wave into clki and emits
// one tick per rising edge, only after a genuine low has been observed.
module xung_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clki,
   input  logic rst,
   input  logic clk_hz,
   output logic tick
);

   logic [SYNC_STAGES-1:0] sync_q;
   // Marks which sync stages hold real samples rather than reset zeros, so a
   // clk_hz held high across reset release cannot arm the detector.
   logic [SYNC_STAGES-1:0] vld_pipe;
   logic                   prev_q;
   logic                   armed_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchronizer chain, one-cycle delay of its output and arming flag.
   always_ff @(posedge clki) begin
      if (rst) begin
         sync_q   <= '0;
         vld_pipe <= '0;
         prev_q   <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_hz};
         vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
         prev_q   <= s;
         if (vld_pipe[SYNC_STAGES-1] && !s)
            armed_q <= 1'b1;
      end
   end

   assign tick = s & ~prev_q & armed_q;

endmodule

// File: rtl/led_tatdan.sv
// led_tatdan: LED bar fill / hold / fade-out ("tat dan") / hold sequencer,
// advanced one step per clk_hz rising edge, fully clocked on clki.
module led_tatdan
   import led_tatdan_pkg::*;
#(
   parameter int N_LED       = 8,
   parameter int HOLD_TICKS  = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clki,
   input  logic               rst,
   input  logic               clk_hz,
   input  logic               en,
   input  logic               dir,
   output logic [N_LED-1:0]   led,
   output logic [PHASE_W-1:0] phase,
   output logic               tick_o
);

   localparam int              CW        = cnt_w(HOLD_TICKS);
   localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_TICKS > 0 ? HOLD_TICKS - 1 : 0);
   localparam logic [N_LED-1:0] ALL_ON   = '1;

   phase_e           state_q, state_d;
   logic [N_LED-1:0] led_q, led_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             tick;

   xung_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
      .clki   (clki),
      .rst    (rst),
      .clk_hz (clk_hz),
      .tick   (tick)
   );

   // Set the highest clear bit.
   function automatic logic [N_LED-1:0] set_top_clear(input logic [N_LED-1:0] v);
      logic [N_LED-1:0] r;
      logic             done;
      r    = v;
      done = 1'b0;
      for (int i = N_LED - 1; i >= 0; i--) begin
         if (!done && !v[i]) begin
            r[i] = 1'b1;
            done = 1'b1;
         end
      end
      return r;
   endfunction

   // Clear the highest set bit.
   function automatic logic [N_LED-1:0] clr_top_set(input logic [N_LED-1:0] v);
      logic [N_LED-1:0] r;
      logic             done;
      r    = v;
      done = 1'b0;
      for (int i = N_LED - 1; i >= 0; i--) begin
         if (!done && v[i]) begin
            r[i] = 1'b0;
            done = 1'b1;
         end
      end
      return r;
   endfunction

   logic [N_LED-1:0] fill_v, drain_v;
   assign fill_v  = dir_q ? set_top_clear(led_q) : (led_q | (led_q + 1'b1));
   assign drain_v = dir_q ? clr_top_set(led_q)   : (led_q & (led_q - 1'b1));

   // State, led, hold counter and latched direction registers.
   always_ff @(posedge clki) begin
      if (rst) begin
         state_q <= PH_IDLE;
         led_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // Next-state logic: everything advances only on tick cycles.
   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         PH_IDLE: begin
            if (tick && en) begin
               state_d = PH_FILL;
               dir_d   = dir;
            end
         end
         PH_FILL: begin
            if (tick) begin
               if (!en) begin
                  state_d = PH_DRAIN;
               end else begin
                  led_d = fill_v;
                  if (fill_v == ALL_ON) begin
                     cnt_d   = '0;
                     state_d = (HOLD_TICKS == 0) ? PH_DRAIN : PH_FULL_HOLD;
                  end
               end
            end
         end
         PH_FULL_HOLD: begin
            if (tick) begin
               if (!en || cnt_q == HOLD_LAST)
                  state_d = PH_DRAIN;
               else
                  cnt_d = cnt_q + 1'b1;
            end
         end
         PH_DRAIN: begin
            if (tick) begin
               led_d = drain_v;
               if (drain_v == '0) begin
                  cnt_d = '0;
                  if (HOLD_TICKS != 0) begin
                     state_d = PH_EMPTY_HOLD;
                  end else if (en) begin
                     state_d = PH_FILL;
                     dir_d   = dir;
                  end else begin
                     state_d = PH_IDLE;
                  end
               end
            end
         end
         PH_EMPTY_HOLD: begin
            if (tick) begin
               if (cnt_q == HOLD_LAST) begin
                  if (en) begin
                     state_d = PH_FILL;
                     dir_d   = dir;
                  end else begin
                     state_d = PH_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = PH_IDLE;
            led_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs come straight from the registers and the edge detector.
   always_comb begin
      led    = led_q;
      phase  = state_q;
      tick_o = tick;
   end

endmodule

// File: tb/tb_led_tatdan.sv
// Self-checking bench for led_tatdan: random pulse widths and enables,
// checked against a window-based model of the lit LED range.
module tb_led_tatdan;

   localparam int N    = 8;
   localparam int HOLD = 2;

   logic       clki = 1'b0;
   logic       rst = 1'b1;
   logic       clk_hz = 1'b0;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] led;
   logic [2:0] phase;
   logic       tick_o;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: lit LEDs are always the contiguous bit range [m_lo, m_hi).
   int m_ph, m_lo, m_hi, m_cnt;
   bit m_dir;

   led_tatdan #(.N_LED(N), .HOLD_TICKS(HOLD), .SYNC_STAGES(2)) dut (
      .clki   (clki),
      .rst    (rst),
      .clk_hz (clk_hz),
      .en     (en),
      .dir    (dir),
      .led    (led),
      .phase  (phase),
      .tick_o (tick_o)
   );

   always #5 clki = ~clki;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_led();
      logic [31:0] v;
      v = ((32'd1 << m_hi) - 32'd1) & ~((32'd1 << m_lo) - 32'd1);
      return v;
   endfunction

   task automatic m_reset();
      m_ph = 0; m_lo = 0; m_hi = 0; m_cnt = 0; m_dir = 0;
   endtask

   task automatic m_restart(input bit e, input bit d);
      if (e) begin
         m_ph = 1; m_dir = d; m_lo = d ? N : 0; m_hi = m_lo;
      end else begin
         m_ph = 0;
      end
   endtask

   task automatic m_step(input bit e, input bit d);
      case (m_ph)
         0: if (e) m_restart(1'b1, d);
         1: begin
            if (!e) m_ph = 3;
            else begin
               if (m_dir) m_lo--; else m_hi++;
               if (m_hi - m_lo == N) begin
                  m_cnt = 0;
                  m_ph  = (HOLD > 0) ? 2 : 3;
               end
            end
         end
         2: begin
            if (!e) m_ph = 3;
            else begin
               m_cnt++;
               if (m_cnt == HOLD) m_ph = 3;
            end
         end
         3: begin
            if (m_hi > m_lo) begin
               if (m_dir) m_hi--; else m_lo++;
            end
            if (m_hi == m_lo) begin
               if (HOLD > 0) begin m_ph = 4; m_cnt = 0; end
               else m_restart(e, d);
            end
         end
         4: begin
            m_cnt++;
            if (m_cnt == HOLD) m_restart(e, d);
         end
         default: m_ph = 0;
      endcase
   endtask

   // One clk_hz period starting and ending at a falling clki edge.
   task automatic pulse(input bit e, input bit d);
      int nt;
      int hi;
      int lo;
      nt = 0;
      hi = $urandom_range(6, 1);
      lo = $urandom_range(8, 3);
      en = e; dir = d; clk_hz = 1'b1;
      repeat (hi) begin @(posedge clki); @(negedge clki); if (tick_o) nt++; end
      clk_hz = 1'b0;
      repeat (lo) begin @(posedge clki); @(negedge clki); if (tick_o) nt++; end
      m_step(e, d);
      chk("tick_count", nt, 1);
      chk("led", led, exp_led());
      chk("phase", phase, m_ph);
   endtask

   task automatic do_reset();
      rst = 1'b1; clk_hz = 1'b0;
      repeat (3) @(posedge clki);
      @(negedge clki);
      rst = 1'b0;
      m_reset();
      repeat (6) begin @(posedge clki); @(negedge clki); end
   endtask

   initial begin
      logic [31:0] old_led;
      int          got;
      int          nt;

      // Reset state
      repeat (3) @(posedge clki);
      @(negedge clki);
      chk("rst_led", led, 0);
      chk("rst_phase", phase, 0);
      chk("rst_tick", tick_o, 0);
      do_reset();

      // Fill LSB first
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
      chk("fill_full_led", led, 32'hFF);
      chk("fill_full_phase", phase, 2);

      // Hold, drain, empty hold, restart
      for (int i = 0; i < 2 + 8 + 2; i++) pulse(1'b1, 1'b0);
      chk("restart_phase", phase, 1);
      pulse(1'b1, 1'(($urandom & 1)));
      chk("restart_led", led, 32'h01);

      // Early stop at 07
      pulse(1'b1, 1'(($urandom & 1)));
      pulse(1'b1, 1'(($urandom & 1)));
      chk("early_led", led, 32'h07);
      pulse(1'b0, 1'b0);
      chk("early_drain_led", led, 32'h07);
      chk("early_drain_phase", phase, 3);
      for (int i = 0; i < 3 + 2; i++) pulse(1'b0, 1'(($urandom & 1)));
      chk("early_idle_phase", phase, 0);

      // MSB-first fill with dir toggling mid-fill, then drain
      pulse(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) pulse(1'b1, 1'(($urandom & 1)));
      chk("msb_full_led", led, 32'hFF);
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
      chk("msb_drain_led", led, 32'h7F);

      // Random enables and directions
      for (int i = 0; i < 40; i++) pulse(1'(($urandom % 5) != 0), 1'(($urandom & 1)));

      // Timing: long high time, single tick, two-edge latency
      en = 1'b1; dir = 1'b0;
      old_led = exp_led();
      clk_hz = 1'b1;
      @(posedge clki); @(negedge clki);
      chk("lat_tick_e1", tick_o, 0);
      chk("lat_led_e1", led, old_led);
      @(posedge clki); @(negedge clki);
      chk("lat_tick_e2", tick_o, 1);
      chk("lat_led_e2", led, old_led);
      m_step(1'b1, 1'b0);
      @(posedge clki); @(negedge clki);
      chk("lat_tick_e3", tick_o, 0);
      chk("lat_led_e3", led, exp_led());
      chk("lat_phase_e3", phase, m_ph);
      nt = 0;
      repeat (1000) begin @(posedge clki); @(negedge clki); if (tick_o) nt++; end
      chk("long_high_extra_ticks", nt, 0);
      clk_hz = 1'b0;
      repeat (5) begin @(posedge clki); @(negedge clki); end

      // Reset during DRAIN at F0, coinciding with a tick
      do_reset();
      for (int i = 0; i < 1 + 8 + 2 + 4; i++) pulse(1'b1, 1'b0);
      chk("pre_rst_led", led, 32'hF0);
      chk("pre_rst_phase", phase, 3);
      clk_hz = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         @(posedge clki); @(negedge clki);
         if (tick_o) got = 1;
      end
      chk("tick_before_rst", got, 1);
      rst = 1'b1;
      @(posedge clki); @(negedge clki);
      chk("rst_over_tick_led", led, 0);
      chk("rst_over_tick_phase", phase, 0);
      rst = 1'b0;
      m_reset();
      nt = 0;
      repeat (20) begin @(posedge clki); @(negedge clki); if (tick_o) nt++; end
      chk("high_across_rst_ticks", nt, 0);
      chk("high_across_rst_phase", phase, 0);
      clk_hz = 1'b0;
      repeat (5) begin @(posedge clki); @(negedge clki); end
      pulse(1'b1, 1'b0);
      chk("after_rearm_phase", phase, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
